minv_bin_ctrl: RTL and testbench



---
 rtl/minv_pkg.sv | 13 +
 rtl/minv_mod_half.sv | 16 +
 rtl/minv_bin_ctrl.sv | 129 ++++++++++++
 tb/tb_minv_bin_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/minv_pkg.sv
// rtl/minv_pkg.sv - shared state encoding and result-flag constants for the binary modular divider
package minv_pkg;

  typedef logic [1:0] minv_state_t;

  localparam minv_state_t ST_IDLE = 2'd0;
  localparam minv_state_t ST_RUN  = 2'd1;
  localparam minv_state_t ST_DONE = 2'd2;

  localparam logic FLAG_X1 = 1'b0;
  localparam logic FLAG_X2 = 1'b1;

endpackage

// File: rtl/minv_mod_half.sv
// rtl/minv_mod_half.sv - x/2 mod p for odd p: x>>1 when x is even, (x+p)>>1 when x is odd
module minv_mod_half #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] half
);

  logic [WIDTH-1:0] p_half;

  // (x+p)>>1 split as (x>>1)+(p>>1)+carry so the WIDTH+1 bit sum never materialises
  assign p_half = (p >> 1) + {{(WIDTH-1){1'b0}}, p[0]};
  assign half   = (x >> 1) + (x[0] ? p_half : '0);

endmodule

// File: rtl/minv_bin_ctrl.sv
// rtl/minv_bin_ctrl.sv - binary extended-Euclid engine computing b * a^-1 mod p, one step per clock
module minv_bin_ctrl
  import minv_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] regx1,
  output logic [WIDTH-1:0] regx2,
  output logic             minv_flag_in,
  output logic             minv_flag_we,
  output logic [CNT_W-1:0] iter_cnt
);

  localparam logic [CNT_W-1:0] MAX_STEPS = CNT_W'(4 * WIDTH);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  minv_state_t      state;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] u;
  logic [WIDTH-1:0] v;

  logic [WIDTH-1:0] half_x1;
  logic [WIDTH-1:0] half_x2;
  logic [WIDTH-1:0] sub_x1;
  logic [WIDTH-1:0] sub_x2;

  minv_mod_half #(.WIDTH(WIDTH)) u_half_x1 (
    .x    (regx1),
    .p    (p_r),
    .half (half_x1)
  );

  minv_mod_half #(.WIDTH(WIDTH)) u_half_x2 (
    .x    (regx2),
    .p    (p_r),
    .half (half_x2)
  );

  // Both operands are < p, so the wrapped WIDTH-bit result equals the true residue
  assign sub_x1 = (regx1 >= regx2) ? (regx1 - regx2) : (regx1 - regx2 + p_r);
  assign sub_x2 = (regx2 >= regx1) ? (regx2 - regx1) : (regx2 - regx1 + p_r);

  assign busy = (state == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      p_r          <= '0;
      u            <= '0;
      v            <= '0;
      regx1        <= '0;
      regx2        <= '0;
      iter_cnt     <= '0;
      err          <= 1'b0;
      done         <= 1'b0;
      minv_flag_in <= 1'b0;
      minv_flag_we <= 1'b0;
    end else begin
      done         <= 1'b0;
      minv_flag_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            p_r          <= p;
            u            <= a;
            v            <= p;
            regx1        <= b;
            regx2        <= '0;
            iter_cnt     <= '0;
            err          <= 1'b0;
            minv_flag_in <= 1'b0;
            state        <= ST_RUN;
          end
        end
        ST_RUN: begin
          // done/flag strobes are registered here so they appear exactly in the DONE cycle
          if (u == '0 || v == '0 || iter_cnt >= MAX_STEPS) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (u == ONE) begin
            minv_flag_in <= FLAG_X1;
            minv_flag_we <= 1'b1;
            done         <= 1'b1;
            state        <= ST_DONE;
          end else if (v == ONE) begin
            minv_flag_in <= FLAG_X2;
            minv_flag_we <= 1'b1;
            done         <= 1'b1;
            state        <= ST_DONE;
          end else if (!u[0]) begin
            u        <= u >> 1;
            regx1    <= half_x1;
            iter_cnt <= iter_cnt + CNT_W'(1);
          end else if (!v[0]) begin
            v        <= v >> 1;
            regx2    <= half_x2;
            iter_cnt <= iter_cnt + CNT_W'(1);
          end else if (u >= v) begin
            u        <= u - v;
            regx1    <= sub_x1;
            iter_cnt <= iter_cnt + CNT_W'(1);
          end else begin
            v        <= v - u;
            regx2    <= sub_x2;
            iter_cnt <= iter_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minv_bin_ctrl.sv
// tb/tb_minv_bin_ctrl.sv - directed table plus corner sequences for minv_bin_ctrl at WIDTH=8
module tb_minv_bin_ctrl;

  localparam int W  = 8;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  p = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  regx1;
  logic [W-1:0]  regx2;
  logic          minv_flag_in;
  logic          minv_flag_we;
  logic [CW-1:0] iter_cnt;

  int errors = 0;
  int checks = 0;

  minv_bin_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .p            (p),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .regx1        (regx1),
    .regx2        (regx2),
    .minv_flag_in (minv_flag_in),
    .minv_flag_we (minv_flag_we),
    .iter_cnt     (iter_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int a;
    int b;
    int inj;
    bit exp_err;
    bit exp_flag;
    bit chk_reg;
    int exp_reg;
    int exp_cnt;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int gcd(input int x, input int y);
    int s = x;
    int t = y;
    while (t != 0) begin
      int r = s % t;
      s = t;
      t = r;
    end
    return s;
  endfunction

  // Starts one operation; inj>0 pulses a conflicting start after that many edges
  task automatic run_op(input int pp, input int aa, input int bb, input int inj,
                        output int cyc, output int we_cnt, output int busy_bad, output bit timeout);
    @(negedge clk);
    p = W'(pp); a = W'(aa); b = W'(bb); start = 1'b1;
    cyc = 0; we_cnt = 0; busy_bad = 0; timeout = 1'b0;
    while (1) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = (inj != 0 && cyc == inj);
      if (start) begin
        p = 8'd7; a = 8'd1; b = 8'd5;
      end
      if (minv_flag_we) we_cnt++;
      if (done) break;
      if (!busy) busy_bad++;
      if (cyc > 500) begin
        timeout = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_vec(input vec_t t, input string tag);
    int cyc, we_cnt, busy_bad;
    bit timeout;
    logic [W-1:0] res;
    run_op(t.p, t.a, t.b, t.inj, cyc, we_cnt, busy_bad, timeout);
    chk({tag, " timeout"}, 32'(timeout), 32'd0);
    chk({tag, " latency"}, 32'(cyc), 32'(t.exp_cnt + 2));
    chk({tag, " iter_cnt"}, 32'(iter_cnt), 32'(t.exp_cnt));
    chk({tag, " err"}, 32'(err), 32'(t.exp_err));
    chk({tag, " flag_in"}, 32'(minv_flag_in), 32'(t.exp_flag));
    chk({tag, " flag_we pulses"}, 32'(we_cnt), t.exp_err ? 32'd0 : 32'd1);
    chk({tag, " busy while running"}, 32'(busy_bad), 32'd0);
    chk({tag, " busy at done"}, 32'(busy), 32'd0);
    if (t.chk_reg) begin
      res = t.exp_flag ? regx2 : regx1;
      chk({tag, " result"}, 32'(res), 32'(t.exp_reg));
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done after"}, 32'(done), 32'd0);
    chk({tag, " flag_we after"}, 32'(minv_flag_we), 32'd0);
    chk({tag, " err held"}, 32'(err), 32'(t.exp_err));
    chk({tag, " iter_cnt held"}, 32'(iter_cnt), 32'(t.exp_cnt));
  endtask

  initial begin
    int cyc, we_cnt, busy_bad, g;
    bit timeout;
    int pp, aa, bb;
    logic [W-1:0] r;

    //         p   a  b  inj err flag chk reg cnt
    tbl[0] = '{13, 3, 1, 0,  0,  1,   1,  9,  4};
    tbl[1] = '{7,  2, 1, 0,  0,  0,   1,  4,  1};
    tbl[2] = '{13, 1, 5, 0,  0,  0,   1,  5,  0};
    tbl[3] = '{13, 3, 2, 0,  0,  1,   1,  5,  4};
    tbl[4] = '{13, 0, 5, 0,  1,  0,   1,  5,  0};
    tbl[5] = '{15, 6, 1, 0,  1,  0,   0,  0,  5};
    tbl[6] = '{13, 3, 1, 2,  0,  1,   1,  9,  4};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset regx1", 32'(regx1), 32'd0);
    chk("reset regx2", 32'(regx2), 32'd0);
    chk("reset flag_in", 32'(minv_flag_in), 32'd0);
    chk("reset flag_we", 32'(minv_flag_we), 32'd0);
    chk("reset iter_cnt", 32'(iter_cnt), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      apply_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of the first case
    @(negedge clk);
    p = 8'd13; a = 8'd3; b = 8'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst busy before", 32'(busy), 32'd1);
    chk("midrst regx2 before", 32'(regx2), 32'd12);
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst err", 32'(err), 32'd0);
    chk("midrst regx1", 32'(regx1), 32'd0);
    chk("midrst regx2", 32'(regx2), 32'd0);
    chk("midrst flag_in", 32'(minv_flag_in), 32'd0);
    chk("midrst flag_we", 32'(minv_flag_we), 32'd0);
    chk("midrst iter_cnt", 32'(iter_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply_vec(tbl[0], "after reset");

    // Random legal operands checked against the modular identity r*a mod p == b
    for (int k = 0; k < 24; k++) begin
      pp = int'($urandom_range(3, 255)) | 1;
      aa = int'($urandom_range(1, pp - 1));
      bb = int'($urandom_range(0, pp - 1));
      g  = gcd(aa, pp);
      run_op(pp, aa, bb, 0, cyc, we_cnt, busy_bad, timeout);
      chk($sformatf("rand%0d timeout", k), 32'(timeout), 32'd0);
      chk($sformatf("rand%0d err p=%0d a=%0d", k, pp, aa), 32'(err), (g == 1) ? 32'd0 : 32'd1);
      if (g == 1) begin
        r = minv_flag_in ? regx2 : regx1;
        chk($sformatf("rand%0d r<p", k), 32'(int'(r) < pp), 32'd1);
        chk($sformatf("rand%0d r*a mod p p=%0d a=%0d b=%0d", k, pp, aa, bb),
            32'((int'(r) * aa) % pp), 32'(bb));
      end
      chk($sformatf("rand%0d latency", k), 32'(cyc), 32'(int'(iter_cnt) + 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
